// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the display encoder and the readback path.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    localparam logic [BCD_W-1:0] BCD_BAD = 4'hF;

    typedef enum logic {
        S_TRACK,
        S_HOLD
    } state_e;

endpackage

// File: rtl/seven_seg_bcd_reader_if.sv
// Frame output bus of the seven-segment reader: decoded frame plus valid/ready handshake.
// The master side presents frames; the slave side consumes them.
interface seven_seg_bcd_reader_if #(
    parameter int NUM_DIGITS = 4
) ();
    import seven_seg_pkg::*;

    logic [BCD_W*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]       dig_err;
    logic                        out_valid;
    logic                        out_ready;
    logic                        overrun;

    modport master (
        output bcd_out,
        output dig_err,
        output out_valid,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  bcd_out,
        input  dig_err,
        input  out_valid,
        input  overrun,
        output out_ready
    );

endinterface

// File: rtl/seg7_pattern_decoder.sv
// Maps a seven-segment pattern back to its BCD digit; anything that is not a
// legal 0-9 glyph (blank included) returns 4'hF with err set.
module seg7_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] bcd,
    output logic             err
);

    always_comb begin
        bcd = BCD_BAD;
        err = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_bcd_reader.sv
// Reads a multiplexed seven-segment bus back into BCD frames after a stability filter.
//   state   | meaning
//   S_TRACK | inputs recently changed, counting identical samples
//   S_HOLD  | current stable window already captured, wait for next change
module seven_seg_bcd_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEG_W-1:0]       seg,
    input  logic [NUM_DIGITS-1:0]  dig_sel,
    seven_seg_bcd_reader_if.master out_if
);

    localparam int FRAME_W = BCD_W * NUM_DIGITS;
    localparam int CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0]    slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0] slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [FRAME_W-1:0]    bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0] dig_err_q, dig_err_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;

    logic                  changed;
    logic                  capture;
    logic                  sel_onehot;
    logic                  out_fire;
    logic [BCD_W-1:0]      dec_bcd;
    logic                  dec_err;

    seg7_pattern_decoder u_dec (
        .seg (seg_q),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // A change is flagged on the edge at which seg_q/sel_q take a new value, so the
    // first stable sample is counted as cnt=0 and capture lands STABLE_CYCLES-1 edges later.
    always_comb begin
        seg_d   = seg;
        sel_d   = dig_sel;
        changed = (seg_d != seg_q) || (sel_d != sel_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (changed) begin
            state_d = S_TRACK;
            cnt_d   = '0;
        end else if (state_q == S_TRACK) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                capture = 1'b1;
                state_d = S_HOLD;
            end
        end
    end

    always_comb begin
        sel_onehot  = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
        out_fire    = out_valid_q && out_if.out_ready;
        slot_bcd_d  = slot_bcd_q;
        slot_err_d  = slot_err_q;
        seen_d      = seen_q;
        bcd_out_d   = bcd_out_q;
        dig_err_d   = dig_err_q;
        out_valid_d = out_valid_q && !out_fire;
        overrun_d   = overrun_q;
        if (capture && sel_onehot) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    slot_bcd_d[i*BCD_W +: BCD_W] = dec_bcd;
                    slot_err_d[i]                = dec_err;
                end
            end
            seen_d = seen_q | sel_q;
            if (&seen_d) begin
                seen_d = '0;
                if (!out_valid_q || out_fire) begin
                    bcd_out_d   = slot_bcd_d;
                    dig_err_d   = slot_err_d;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= '0;
            sel_q       <= '0;
            state_q     <= S_TRACK;
            cnt_q       <= '0;
            slot_bcd_q  <= '0;
            slot_err_q  <= '0;
            seen_q      <= '0;
            bcd_out_q   <= '0;
            dig_err_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_bcd_q  <= slot_bcd_d;
            slot_err_q  <= slot_err_d;
            seen_q      <= seen_d;
            bcd_out_q   <= bcd_out_d;
            dig_err_q   <= dig_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.bcd_out   = bcd_out_q;
    assign out_if.dig_err   = dig_err_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_seven_seg_bcd_reader.sv
// Bench for seven_seg_bcd_reader: directed scenarios plus random traffic, checked
// against a run-length reference model through a frame scoreboard.
module tb_seven_seg_bcd_reader;

    localparam int N = 4;
    localparam int S = 8;

    typedef struct {
        logic [4*N-1:0] bcd;
        logic [N-1:0]   err;
    } frame_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   seg_i = '0;
    logic [N-1:0] dig_i = '0;

    seven_seg_bcd_reader_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_bcd_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg_i),
        .dig_sel (dig_i),
        .out_if  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model state
    int           run;
    logic [6:0]   prev_seg;
    logic [N-1:0] prev_sel;
    int           m_dig  [N];
    bit           m_seen [N];
    bit           m_valid;
    bit           m_overrun;
    frame_t       sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode7(input logic [6:0] s);
        for (int k = 0; k < 10; k++)
            if (seg_tbl[k] == s) return k;
        return 15;
    endfunction

    task automatic model_reset();
        run       = 1;
        prev_seg  = '0;
        prev_sel  = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_dig[i]  = 0;
            m_seen[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    // A pattern is captured on the edge where it has been sampled S times in a row.
    task automatic model_step();
        bit     hs, load, all_seen;
        frame_t f;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hs = m_valid && bus.out_ready;
        if (seg_i == prev_seg && dig_i == prev_sel) run++;
        else begin
            run      = 1;
            prev_seg = seg_i;
            prev_sel = dig_i;
        end
        load = 1'b0;
        if (run == S && $countones(dig_i) == 1) begin
            for (int i = 0; i < N; i++)
                if (dig_i[i]) begin
                    m_dig[i]  = decode7(seg_i);
                    m_seen[i] = 1'b1;
                end
            all_seen = 1'b1;
            for (int i = 0; i < N; i++) all_seen &= m_seen[i];
            if (all_seen) begin
                for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
                if (!m_valid || hs) load = 1'b1;
                else m_overrun = 1'b1;
            end
        end
        if (load) begin
            for (int i = 0; i < N; i++) begin
                f.bcd[4*i +: 4] = 4'(m_dig[i]);
                f.err[i]        = (m_dig[i] == 15);
            end
            sb_q.push_back(f);
            m_valid = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // monitor: flags every cycle, frame contents on each handshake
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            check("out_valid", bus.out_valid, m_valid);
            check("overrun", bus.overrun, m_overrun);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame: got unexpected frame %h, expected none", bus.bcd_out);
                end else begin
                    f = sb_q.pop_front();
                    check("frame bcd_out", bus.bcd_out, f.bcd);
                    check("frame dig_err", bus.dig_err, f.err);
                end
            end
        end
    end

    task automatic hold(input logic [6:0] s, input logic [N-1:0] d, input int n);
        seg_i = s;
        dig_i = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [6:0] p3);
        hold(p0, 4'b0001, S + 2);
        hold(p1, 4'b0010, S + 2);
        hold(p2, 4'b0100, S + 2);
        hold(p3, 4'b1000, S + 2);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        hold(7'h00, '0, 3);
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0]   p;
        logic [N-1:0] d;
        int           r;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset bcd_out", bus.bcd_out, 0);
        check("reset dig_err", bus.dig_err, 0);

        // walk digits 2,3,4,5
        hold(7'h5B, 4'b0001, 20);
        check("single digit no valid", bus.out_valid, 0);
        hold(7'h4F, 4'b0010, S + 2);
        hold(7'h66, 4'b0100, S + 2);
        hold(7'h6D, 4'b1000, S + 2);
        check("walk valid", bus.out_valid, 1);
        check("walk bcd_out", bus.bcd_out, 16'h5432);
        check("walk dig_err", bus.dig_err, 0);
        drain();

        // glitch on digit 2 must not be captured
        hold(7'h3F, 4'b0001, S + 2);
        hold(7'h7D, 4'b0010, S + 2);
        hold(7'h06, 4'b0100, 5);
        hold(7'h7F, 4'b0100, 8);
        hold(7'h07, 4'b1000, S + 2);
        check("glitch bcd_out", bus.bcd_out, 16'h7860);
        drain();

        // illegal pattern on digit 1
        frame4(7'h3F, 7'h49, 7'h5B, 7'h4F);
        check("illegal bcd_out", bus.bcd_out, 16'h32F0);
        check("illegal dig_err", bus.dig_err, 4'b0010);
        drain();

        // backpressure: second frame dropped
        pulse_reset();
        frame4(7'h06, 7'h5B, 7'h4F, 7'h66);
        frame4(7'h7D, 7'h07, 7'h7F, 7'h6F);
        check("bp held bcd_out", bus.bcd_out, 16'h4321);
        check("bp overrun", bus.overrun, 1);
        bus.out_ready = 1'b1;
        hold(7'h00, '0, 1);
        check("bp valid dropped", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // accept and load on the same edge
        pulse_reset();
        frame4(7'h06, 7'h5B, 7'h4F, 7'h66);
        hold(7'h5B, 4'b0001, S + 2);
        hold(7'h7D, 4'b0010, S + 2);
        hold(7'h3F, 4'b0100, S + 2);
        seg_i = 7'h6F;
        dig_i = 4'b1000;
        repeat (S - 1) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("simul valid", bus.out_valid, 1);
        check("simul bcd_out", bus.bcd_out, 16'h9062);
        check("simul overrun", bus.overrun, 0);
        drain();

        // reset mid-frame discards partial frame
        hold(7'h06, 4'b0001, S + 2);
        hold(7'h5B, 4'b0010, S + 2);
        seg_i = '0;
        dig_i = '0;
        pulse_reset();
        hold(7'h4F, 4'b0100, S + 2);
        hold(7'h66, 4'b1000, S + 2);
        check("midreset valid", bus.out_valid, 0);
        check("midreset bcd_out", bus.bcd_out, 0);
        check("midreset dig_err", bus.dig_err, 0);

        // random traffic
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            p = (r == 9) ? 7'($urandom) : seg_tbl[$urandom_range(0, 9)];
            r = $urandom_range(0, 9);
            if (r < 8)       d = N'(1) << $urandom_range(0, N - 1);
            else if (r == 8) d = '0;
            else             d = N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            hold(p, d, $urandom_range(2, 14));
        end
        bus.out_ready = 1'b1;
        hold(7'h00, '0, S + 4);
        check("scoreboard drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
